lcd_ctrl: RTL and testbench

Hardware HD44780 write controller that owns the character-LCD side of the memory-mapped I/O path. The CPU hands it bytes over a valid/ready handshake, and the controller produces all LCD bus timing: setup, EN pulse, hold and execution wait. After reset it runs the power-on init sequence on its own. Its 32-bit output word uses the same bit packing as the core's `io_lcd_o` port, so it drops into the board wrapper in place of software bit-banging.

---
 rtl/lcd_req_if.sv | 10 +
 rtl/lcd_ctrl.sv | 136 +++++++++++++
 tb/tb_lcd_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_req_if.sv
// Byte request channel from the CPU side into the LCD write controller.
interface lcd_req_if;
    logic       valid;
    logic       ready;
    logic       rs;
    logic [7:0] data;

    modport master (output valid, output rs, output data, input ready);
    modport slave  (input valid, input rs, input data, output ready);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780 write controller: power-on init sequence, then CPU byte writes with
// full setup / EN pulse / hold / execution-wait timing on a packed 32-bit bus word.
module lcd_ctrl #(
    parameter int T_SETUP   = 4,
    parameter int T_EN      = 25,
    parameter int T_HOLD    = 2,
    parameter int T_EXEC    = 2500,
    parameter int T_CLEAR   = 82000,
    parameter int T_POWERUP = 750000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    lcd_req_if.slave    req,
    input  logic        lcd_on_i,
    output logic        busy_o,
    output logic [31:0] io_lcd_o
);
    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXP  = max2(max2(max2(T_SETUP, T_EN), max2(T_HOLD, T_EXEC)),
                                max2(T_CLEAR, T_POWERUP));
    localparam int NEED  = $clog2(MAXP + 1);
    // One shared down-counter sized for the longest wait, never under 20 bits.
    localparam int CW    = (NEED > 20) ? NEED : 20;

    typedef enum logic [2:0] {
        PWR_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, EXEC, IDLE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic            init_done;
    logic            long_q;
    logic            on_q, en_q, rs_q, ready_q, busy_q;
    logic [7:0]      data_q;

    function automatic logic [7:0] init_rom(logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            default:          return 8'h06;
        endcase
    endfunction

    // Clear and Home need the long execution wait.
    function automatic logic is_long(logic rs, logic [7:0] d);
        return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    endfunction

    // Sequencer: every bus field and handshake output is a register updated here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= PWR_WAIT;
            cnt       <= CW'(T_POWERUP - 1);
            idx       <= '0;
            init_done <= 1'b0;
            long_q    <= 1'b0;
            on_q      <= 1'b0;
            en_q      <= 1'b0;
            rs_q      <= 1'b0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            on_q <= lcd_on_i;
            case (state)
                PWR_WAIT: begin
                    if (cnt == '0) state <= INIT_LOAD;
                    else           cnt   <= cnt - 1'b1;
                end
                INIT_LOAD: begin
                    data_q <= init_rom(idx);
                    rs_q   <= 1'b0;
                    long_q <= is_long(1'b0, init_rom(idx));
                    cnt    <= CW'(T_SETUP - 1);
                    state  <= SETUP;
                end
                SETUP: begin
                    if (cnt == '0) begin
                        en_q  <= 1'b1;
                        cnt   <= CW'(T_EN - 1);
                        state <= PULSE;
                    end else cnt <= cnt - 1'b1;
                end
                PULSE: begin
                    if (cnt == '0) begin
                        en_q  <= 1'b0;
                        cnt   <= CW'(T_HOLD - 1);
                        state <= HOLD;
                    end else cnt <= cnt - 1'b1;
                end
                HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= long_q ? CW'(T_CLEAR - 1) : CW'(T_EXEC - 1);
                        state <= EXEC;
                    end else cnt <= cnt - 1'b1;
                end
                EXEC: begin
                    if (cnt == '0) begin
                        if (!init_done && idx != 3'd5) begin
                            idx   <= idx + 1'b1;
                            state <= INIT_LOAD;
                        end else begin
                            init_done <= 1'b1;
                            ready_q   <= 1'b1;
                            busy_q    <= 1'b0;
                            state     <= IDLE;
                        end
                    end else cnt <= cnt - 1'b1;
                end
                IDLE: begin
                    // ready_q is only ever high here, so this is the handshake cycle.
                    if (req.valid && ready_q) begin
                        rs_q    <= req.rs;
                        data_q  <= req.data;
                        long_q  <= is_long(req.rs, req.data);
                        cnt     <= CW'(T_SETUP - 1);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= SETUP;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

    assign req.ready = ready_q;
    assign busy_o    = busy_q;
    // RW is tied low: write-only controller.
    assign io_lcd_o  = {on_q, 20'b0, en_q, rs_q, 1'b0, data_q};
endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing parameters.
module tb_lcd_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lcd_on = 1'b0;
    logic        busy;
    logic [31:0] io;
    int          vectors = 0;
    int          errors  = 0;
    int          bad_static = 0;

    lcd_req_if req ();

    lcd_ctrl #(.T_SETUP(2), .T_EN(3), .T_HOLD(1), .T_EXEC(5), .T_CLEAR(20), .T_POWERUP(10)) dut (
        .clk_i(clk), .rst_i(rst), .req(req), .lcd_on_i(lcd_on), .busy_o(busy), .io_lcd_o(io)
    );

    always #5 clk = ~clk;

    // Bits 30:11 and RW must be zero in every cycle.
    always @(negedge clk) if (io[30:11] != 20'd0 || io[8] != 1'b0) bad_static++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after the reset edge sample; follows the init sequence to IDLE.
    task automatic run_init(string tag);
        int rise_t[6];
        int width[6];
        int gap[5];
        logic [7:0] dat[6];
        logic rsb[6];
        int npulse, fall_t, ready_t, busy_low;
        logic en_prev;
        npulse = 0; fall_t = 0; ready_t = -1; busy_low = 0; en_prev = 1'b0;
        for (int i = 0; i < 6; i++) begin rise_t[i] = -1; width[i] = -1; dat[i] = 8'h00; rsb[i] = 1'b1; end
        for (int i = 0; i < 5; i++) gap[i] = -1;
        for (int t = 1; t <= 400; t++) begin
            tick();
            if (io[10] && !en_prev) begin
                if (npulse < 6) begin
                    rise_t[npulse] = t; dat[npulse] = io[7:0]; rsb[npulse] = io[9];
                    if (npulse > 0) gap[npulse-1] = t - fall_t;
                end
                npulse++;
            end
            if (!io[10] && en_prev) begin
                if (npulse >= 1 && npulse <= 6) width[npulse-1] = t - rise_t[npulse-1];
                fall_t = t;
            end
            en_prev = io[10];
            if (req.ready) begin ready_t = t; break; end
            if (!busy) busy_low++;
        end
        chk({tag, " pulse count"}, npulse, 6);
        chk({tag, " first EN rise"}, rise_t[0], 13);
        chk({tag, " ready rise"}, ready_t, 97);
        chk({tag, " busy during init"}, busy_low, 0);
        chk({tag, " busy at idle"}, busy, 1'b0);
        chk({tag, " data0"}, dat[0], 8'h38);
        chk({tag, " data1"}, dat[1], 8'h38);
        chk({tag, " data2"}, dat[2], 8'h38);
        chk({tag, " data3"}, dat[3], 8'h0C);
        chk({tag, " data4"}, dat[4], 8'h01);
        chk({tag, " data5"}, dat[5], 8'h06);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s rs%0d", tag, i), rsb[i], 1'b0);
            chk($sformatf("%s width%0d", tag, i), width[i], 3);
        end
        // EN-low gap = hold + wait + INIT_LOAD + setup: 9 normally, 24 after Clear.
        for (int i = 0; i < 5; i++)
            chk($sformatf("%s gap%0d", tag, i), gap[i], (i == 4) ? 24 : 9);
    endtask

    initial begin
        logic en_s[0:30];
        logic rdy_s[0:30];
        int npulse;
        logic en_prev;
        req.valid = 1'b0; req.rs = 1'b0; req.data = 8'h00;

        // Reset and init
        rst = 1'b1;
        tick();
        chk("reset io", io, 32'h0);
        chk("reset busy", busy, 1'b1);
        chk("reset ready", req.ready, 1'b0);
        // Drive a request during reset/init; it must never be accepted.
        req.valid = 1'b1; req.rs = 1'b1; req.data = 8'hAA;
        rst = 1'b0;
        run_init("init");
        chk("init data untouched", io[7:0], 8'h06);
        req.valid = 1'b0;

        // LCD_ON path
        lcd_on = 1'b1;
        chk("on before edge", io[31], 1'b0);
        tick();
        chk("on after edge", io[31], 1'b1);
        lcd_on = 1'b0;
        tick();
        chk("on low", io[31], 1'b0);
        lcd_on = 1'b1;
        tick();

        // Data write RS=1, 0x41
        req.valid = 1'b1; req.rs = 1'b1; req.data = 8'h41;
        tick();
        req.valid = 1'b0; req.data = 8'h55;
        chk("write setup word", io, 32'h8000_0241);
        chk("write busy", busy, 1'b1);
        for (int k = 2; k <= 12; k++) begin tick(); en_s[k] = io[10]; rdy_s[k] = req.ready; end
        chk("write en N+2", en_s[2], 1'b0);
        chk("write en N+3..5", {en_s[3], en_s[4], en_s[5]}, 3'b111);
        chk("write en N+6", en_s[6], 1'b0);
        chk("write ready N+11", rdy_s[11], 1'b0);
        chk("write ready N+12", rdy_s[12], 1'b1);
        chk("write fields held", io[9:0], 10'h241);

        // Clear command
        req.valid = 1'b1; req.rs = 1'b0; req.data = 8'h01;
        tick();
        req.valid = 1'b0;
        chk("clear setup", io[10:0], 11'h001);
        for (int k = 2; k <= 27; k++) begin tick(); if (k <= 30) rdy_s[k] = req.ready; end
        chk("clear ready N+12", rdy_s[12], 1'b0);
        chk("clear ready N+26", rdy_s[26], 1'b0);
        chk("clear ready N+27", rdy_s[27], 1'b1);

        // Back-to-back with valid held high
        req.valid = 1'b1; req.rs = 1'b1; req.data = 8'h48;
        tick();
        req.data = 8'h49;
        chk("b2b first", io[9:0], 10'h248);
        npulse = 0; en_prev = io[10];
        for (int k = 2; k <= 13; k++) begin
            tick();
            rdy_s[k] = req.ready;
            if (io[10] && !en_prev) npulse++;
            en_prev = io[10];
            if (k == 12) chk("b2b not recaptured", io[7:0], 8'h48);
        end
        chk("b2b ready N+12", rdy_s[12], 1'b1);
        chk("b2b second accepted", io[9:0], 10'h249);
        chk("b2b ready dropped", rdy_s[13], 1'b0);
        req.valid = 1'b0;
        for (int k = 0; k < 40 && !req.ready; k++) begin
            tick();
            if (io[10] && !en_prev) npulse++;
            en_prev = io[10];
        end
        chk("b2b pulses", npulse, 2);
        chk("b2b back to idle", req.ready, 1'b1);

        // Reset mid-pulse
        req.valid = 1'b1; req.rs = 1'b1; req.data = 8'h5A;
        tick();
        req.valid = 1'b0;
        tick(); tick();
        chk("mid pulse en", io[10], 1'b1);
        rst = 1'b1;
        tick();
        chk("mid reset en", io[10], 1'b0);
        chk("mid reset busy", busy, 1'b1);
        chk("mid reset io", io, 32'h0);
        rst = 1'b0;
        run_init("reinit");

        chk("static bits zero", bad_static, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
